// File: rtl/regex_nth_last_matcher_pkg.sv
// rtl/regex_nth_last_matcher_pkg.sv - shared defaults and saturating increment for the nth-last matcher
package regex_pkg;

  localparam int DEF_N     = 20;
  localparam int DEF_POS_W = 16;
  localparam int DEF_CNT_W = 16;

  // Increment val, sticking at the all-ones value of a w-bit field
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (val >= max_v) ? max_v : (val + 32'd1);
  endfunction

endpackage

// File: rtl/regex_nth_last_matcher_if.sv
// rtl/regex_nth_last_matcher_if.sv - char stream in / verdict out bundle; MATCH_COUNT_EN adds the counter signals
interface regex_nth_last_matcher_if
  import regex_pkg::*;
#(
  parameter int POS_W = DEF_POS_W
`ifdef MATCH_COUNT_EN
  ,
  parameter int CNT_W = DEF_CNT_W
`endif
);

  logic             i_valid;
  logic             i_c;
  logic             lit;
  logic             o_valid;
  logic             o;
  logic [POS_W-1:0] pos;
`ifdef MATCH_COUNT_EN
  logic [CNT_W-1:0] match_cnt;
  logic [POS_W-1:0] first_pos;
  logic             first_vld;
`endif

`ifdef MATCH_COUNT_EN
  modport master (
    output i_valid, i_c, lit,
    input  o_valid, o, pos, match_cnt, first_pos, first_vld
  );
  modport slave (
    input  i_valid, i_c, lit,
    output o_valid, o, pos, match_cnt, first_pos, first_vld
  );
`else
  modport master (
    output i_valid, i_c, lit,
    input  o_valid, o, pos
  );
  modport slave (
    input  i_valid, i_c, lit,
    output o_valid, o, pos
  );
`endif

endinterface

// File: rtl/regex_char_cell.sv
// rtl/regex_char_cell.sv - one NFA position: enabled d register with synchronous flush
module regex_char_cell (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);

  logic r_q;

  // A char load beats a flush so the head cell can start a new string in the clear cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 1'b0;
    end else if (i_en) begin
      r_q <= i_d;
    end else if (i_clr) begin
      r_q <= 1'b0;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/regex_nth_last_matcher.sv
// rtl/regex_nth_last_matcher.sv - streaming (0|1)*.L.(0|1){N} matcher; MATCH_COUNT_EN adds match counters
module regex_nth_last_matcher
  import regex_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int POS_W = DEF_POS_W
`ifdef MATCH_COUNT_EN
  ,
  parameter int CNT_W = DEF_CNT_W
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  regex_nth_last_matcher_if.slave bus
);

  logic [N:0]       w_s;
  logic             w_match;
  logic             r_valid;
  logic [POS_W-1:0] r_pos;

  // The star state is always live, so the head cell just records whether this char is L
  assign w_match = (bus.i_c == bus.lit);

  genvar k;
  generate
    for (k = 0; k <= N; k++) begin : g_cell
      logic w_d;
      if (k == 0) begin : g_head
        assign w_d = w_match;
      end else begin : g_tail
        // A clear in the same cycle as a char must not shift old state down the chain
        assign w_d = clear ? 1'b0 : w_s[k-1];
      end
      regex_char_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .i_clr (clear),
        .i_en  (bus.i_valid),
        .i_d   (w_d),
        .o_q   (w_s[k])
      );
    end
  endgenerate

  // Per-char pulse and saturating position; a clear with a char makes that char number one
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pos   <= '0;
    end else if (bus.i_valid) begin
      r_valid <= 1'b1;
      r_pos   <= clear ? POS_W'(1) : POS_W'(sat_inc(32'(r_pos), POS_W));
    end else begin
      r_valid <= 1'b0;
      if (clear) begin
        r_pos <= '0;
      end
    end
  end

  // The last cell is itself the verdict register: it holds across gaps and clears with the string
  assign bus.o       = w_s[N];
  assign bus.o_valid = r_valid;
  assign bus.pos     = r_pos;

`ifdef MATCH_COUNT_EN
  logic [CNT_W-1:0] r_match_cnt;
  logic [POS_W-1:0] r_first_pos;
  logic             r_first_vld;
  logic             w_hit;

  assign w_hit = r_valid && w_s[N];

  // Count verdict pulses and latch the position of the first one in the string
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_match_cnt <= '0;
      r_first_pos <= '0;
      r_first_vld <= 1'b0;
    end else if (w_hit) begin
      r_match_cnt <= CNT_W'(sat_inc(32'(r_match_cnt), CNT_W));
      if (!r_first_vld) begin
        r_first_pos <= r_pos;
        r_first_vld <= 1'b1;
      end
    end
  end

  assign bus.match_cnt = r_match_cnt;
  assign bus.first_pos = r_first_pos;
  assign bus.first_vld = r_first_vld;
`endif

endmodule
